// File: rtl/prefetcher_ar_arbiter.sv
// Arbitrates NUM_SLICES slice AR requests onto one master AXI read port
// and routes R beats back by learned ID. Option: PR_ARB_FIXED_PRIO_EN.
module prefetcher_ar_arbiter #(
    parameter int NUM_SLICES      = 4,
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    localparam int IW             = $clog2(NUM_SLICES)
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            en,
    input  logic [NUM_SLICES-1:0]           sl_ar_valid,
    output logic [NUM_SLICES-1:0]           sl_ar_ready,
    input  logic [NUM_SLICES*ADDR_BITS-1:0] sl_ar_addr,
    input  logic [NUM_SLICES*BURST_LEN_WIDTH-1:0] sl_ar_len,
    input  logic [NUM_SLICES*TID_WIDTH-1:0] sl_ar_id,
    input  logic [NUM_SLICES-1:0]           sl_ctx_valid,
    input  logic [NUM_SLICES*TID_WIDTH-1:0] sl_ctx_id,
    output logic [NUM_SLICES-1:0]           sl_r_valid,
    input  logic [NUM_SLICES-1:0]           sl_r_ready,
    output logic                            m_ar_valid,
    input  logic                            m_ar_ready,
    output logic [ADDR_BITS-1:0]            m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]      m_ar_len,
    output logic [TID_WIDTH-1:0]            m_ar_id,
    input  logic                            m_r_valid,
    input  logic [TID_WIDTH-1:0]            m_r_id,
    output logic                            m_r_ready,
    output logic                            r_orphan,
    output logic [IW-1:0]                   grant_idx
);

    typedef enum logic {
        ST_ARB_IDLE,
        ST_ARB_BUSY
    } arb_state_t;

    arb_state_t    state;
    logic          win_found;
    logic [IW-1:0] win_idx;
    logic          grant;
    logic          match_found;
    logic [IW-1:0] match_idx;

`ifndef PR_ARB_FIXED_PRIO_EN
    logic [IW-1:0] last;
`endif

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef PR_ARB_FIXED_PRIO_EN
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (sl_ar_valid[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
`else
        // Scan downwards so the slice right after last overwrites the rest
        for (int k = NUM_SLICES; k >= 1; k--) begin
            if (sl_ar_valid[(int'(last) + k) % NUM_SLICES]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(last) + k) % NUM_SLICES);
            end
        end
`endif
    end

    assign grant = en && (state == ST_ARB_IDLE) && win_found;

    always_comb begin
        sl_ar_ready = '0;
        if (grant) begin
            sl_ar_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= ST_ARB_IDLE;
            m_ar_valid <= 1'b0;
            m_ar_addr  <= '0;
            m_ar_len   <= '0;
            m_ar_id    <= '0;
            grant_idx  <= '0;
`ifndef PR_ARB_FIXED_PRIO_EN
            last       <= IW'(NUM_SLICES - 1);
`endif
        end else if (en) begin
            unique case (state)
                ST_ARB_IDLE: begin
                    if (win_found) begin
                        m_ar_addr  <= sl_ar_addr[win_idx*ADDR_BITS +: ADDR_BITS];
                        m_ar_len   <= sl_ar_len[win_idx*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
                        m_ar_id    <= sl_ar_id[win_idx*TID_WIDTH +: TID_WIDTH];
                        m_ar_valid <= 1'b1;
                        grant_idx  <= win_idx;
`ifndef PR_ARB_FIXED_PRIO_EN
                        last       <= win_idx;
`endif
                        state      <= ST_ARB_BUSY;
                    end
                end
                ST_ARB_BUSY: begin
                    if (m_ar_ready) begin
                        m_ar_valid <= 1'b0;
                        state      <= ST_ARB_IDLE;
                    end
                end
                default: state <= ST_ARB_IDLE;
            endcase
        end
    end

    // R routing: lowest-index matching context owns the beat
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = NUM_SLICES - 1; i >= 0; i--) begin
            if (sl_ctx_valid[i] &&
                sl_ctx_id[i*TID_WIDTH +: TID_WIDTH] == m_r_id) begin
                match_found = 1'b1;
                match_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        sl_r_valid = '0;
        if (m_r_valid && match_found) begin
            sl_r_valid[match_idx] = 1'b1;
        end
        m_r_ready = m_r_valid &&
                    (match_found ? sl_r_ready[match_idx] : 1'b1);
        r_orphan  = m_r_valid && !match_found;
    end

endmodule
